// File: rtl/fixed_point_acc.sv
// Streaming signed accumulator: sums a LAST_IN/term-count delimited burst into one WIDTH-bit result.
// Define FIXED_POINT_ACC_SATURATION_EN to clamp out-of-range sums instead of wrapping.
module fixed_point_acc #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_GUARD = 4,
   parameter int unsigned MAX_TERMS = 16
) (
   input  logic                             CLK,
   input  logic                             RSTN,
   input  logic                             CLEAR_IN,
   input  logic [WIDTH-1:0]                 VALUE_IN,
   input  logic                             VALID_IN,
   input  logic                             LAST_IN,
   output logic                             READY_OUT,
   output logic [WIDTH-1:0]                 VALUE_OUT,
   output logic [$clog2(MAX_TERMS+1)-1:0]   COUNT_OUT,
   output logic                             OVERFLOW,
   output logic                             VALID_OUT,
   input  logic                             READY_IN
);

   localparam int unsigned AW = WIDTH + ACC_GUARD;
   localparam int unsigned CW = $clog2(MAX_TERMS + 1);
   localparam logic [CW-1:0] MaxCnt = CW'(MAX_TERMS);
   localparam logic [CW-1:0] OneCnt = CW'(1);

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     cnt_out_q, cnt_out_d;
   logic [WIDTH-1:0]  value_q, value_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;

   logic              accept;
   logic [AW-1:0]     term;
   logic [AW-1:0]     sum;
   logic [CW-1:0]     count_next;
   logic              last_term;
   logic [ACC_GUARD:0] upper;
   logic              in_range;
   logic [WIDTH-1:0]  result;

   assign READY_OUT = (state_q != StHold) && !CLEAR_IN;
   assign accept    = VALID_IN && READY_OUT;

   assign term       = {{ACC_GUARD{VALUE_IN[WIDTH-1]}}, VALUE_IN};
   assign sum        = (state_q == StAccum) ? acc_q + term : term;
   assign count_next = (state_q == StAccum) ? count_q + OneCnt : OneCnt;
   assign last_term  = LAST_IN || (count_next == MaxCnt);

   // The sum fits WIDTH bits only when the guard bits all copy the WIDTH-bit sign bit.
   assign upper    = sum[AW-1:WIDTH-1];
   assign in_range = (&upper) || !(|upper);

`ifdef FIXED_POINT_ACC_SATURATION_EN
   assign result = in_range ? sum[WIDTH-1:0] :
                   (sum[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
   assign result = sum[WIDTH-1:0];
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      count_d   = count_q;
      cnt_out_d = cnt_out_q;
      value_d   = value_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      if (CLEAR_IN) begin
         state_d = StIdle;
         acc_d   = '0;
         count_d = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StAccum: begin
               if (accept) begin
                  acc_d   = sum;
                  count_d = count_next;
                  if (last_term) begin
                     value_d   = result;
                     cnt_out_d = count_next;
                     ovf_d     = !in_range;
                     valid_d   = 1'b1;
                     state_d   = StHold;
                  end else begin
                     state_d = StAccum;
                  end
               end
            end
            StHold: begin
               if (READY_IN) begin
                  valid_d = 1'b0;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         count_q   <= '0;
         cnt_out_q <= '0;
         value_q   <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         cnt_out_q <= cnt_out_d;
         value_q   <= value_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
      end
   end

   assign VALUE_OUT = value_q;
   assign COUNT_OUT = cnt_out_q;
   assign OVERFLOW  = ovf_q;
   assign VALID_OUT = valid_q;

endmodule
